// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM encoding, requester indices and latency limits for mem_arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2} state_t;
    localparam logic REQ_CORE    = 1'b0;
    localparam logic REQ_AUX     = 1'b1;
    localparam int   MEM_LAT_MIN = 1;
    localparam int   MEM_LAT_MAX = 4;
    // Counter value in WAIT at which the access completes.
    function automatic logic [2:0] ack_count(input logic wr, input int lat);
        return wr ? 3'd1 : 3'(lat);
    endfunction
endpackage

// File: rtl/mem_arbiter_pick.sv
// arb_pick: combinational two-way winner selection; on contention the requester not granted last wins.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner,
    output logic valid
);
    always_comb begin
        valid  = req0 | req1;
        winner = (req0 && req1) ? (last == REQ_CORE ? REQ_AUX : REQ_CORE) : (req1 ? REQ_AUX : REQ_CORE);
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester single-port memory arbiter, one transaction outstanding.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        we0,
    input  logic        we1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic [31:0] address,
    output logic [31:0] data_out,
    output logic        we,
    input  logic [31:0] data_in
);
    localparam int LAT = MEM_LAT < MEM_LAT_MIN ? MEM_LAT_MIN : MEM_LAT > MEM_LAT_MAX ? MEM_LAT_MAX : MEM_LAT;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_wr;
    logic        r_win;
    logic        w_win;
    logic        w_valid;
    logic        w_last;
    logic        w_done;
    logic        w_take;

    assign w_take = (r_state == IDLE) && w_valid;
    assign w_done = (r_state == WAIT) && (r_cnt == ack_count(r_wr, LAT));

`ifdef MEM_ARB_RR_EN
    logic r_last;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_last <= REQ_AUX;
        else if (w_take)
            r_last <= w_win;
    end
    assign w_last = r_last;
`else
    assign w_last = REQ_AUX;
`endif

    arb_pick u_pick (
        .req0  (req0),
        .req1  (req1),
        .last  (w_last),
        .winner(w_win),
        .valid (w_valid)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state == IDLE ? (w_valid ? ACCESS : IDLE) :
                 r_state == ACCESS ? WAIT :
                 (r_state == WAIT && !w_done) ? WAIT : IDLE;
    end

    always_comb begin
        gnt0  = (r_state == ACCESS) && (r_win == REQ_CORE);
        gnt1  = (r_state == ACCESS) && (r_win == REQ_AUX);
        we    = (r_state == ACCESS) && r_wr;
        ack0  = w_done && (r_win == REQ_CORE);
        ack1  = w_done && (r_win == REQ_AUX);
        rdata = w_done ? data_in : 32'd0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= 3'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wr    <= 1'b0;
            r_win   <= REQ_CORE;
        end else begin
            if (w_take) begin
                r_addr  <= w_win ? addr1 : addr0;
                r_wdata <= w_win ? wdata1 : wdata0;
                r_wr    <= w_win ? we1 : we0;
                r_win   <= w_win;
            end
            r_cnt <= r_state == ACCESS ? 3'd1 : r_state == WAIT ? r_cnt + 3'd1 : 3'd0;
        end
    end

    assign address  = r_addr;
    assign data_out = r_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (MEM_LAT=1 and MEM_LAT=3 instances).
module tb_mem_arbiter;
    logic        clk = 1'b0, resetn = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0, data_in = '0;
    logic        gnt0, gnt1, ack0, ack1, we;
    logic [31:0] rdata, address, data_out;
    logic        g0_3, g1_3, a0_3, a1_3, we_3;
    logic [31:0] rd_3, ad_3, do_3;
    int          checks = 0, failures = 0;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(1)) dut (
        .clk(clk), .resetn(resetn), .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1), .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata(rdata), .address(address), .data_out(data_out), .we(we), .data_in(data_in)
    );

    mem_arbiter #(.MEM_LAT(3)) dut3 (
        .clk(clk), .resetn(resetn), .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1), .gnt0(g0_3), .gnt1(g1_3), .ack0(a0_3), .ack1(a1_3),
        .rdata(rd_3), .address(ad_3), .data_out(do_3), .we(we_3), .data_in(data_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        tick(2);
        resetn = 1'b1;
    endtask

    initial begin
        // Reset state, checked before any clock edge
        #2;
        chk("rst_ctl", {27'd0, gnt0, gnt1, ack0, ack1, we}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_addr", address, 32'd0);
        chk("rst_dout", data_out, 32'd0);
        tick(2);
        resetn = 1'b1;

        // Single read, MEM_LAT=1
        req0 = 1'b1; addr0 = 32'h100; we0 = 1'b0;
        tick();
        chk("rd_gnt0", gnt0, 1);
        chk("rd_gnt1", gnt1, 0);
        chk("rd_addr", address, 32'h100);
        chk("rd_we", we, 0);
        chk("rd_noack", ack0, 0);
        req0 = 1'b0; data_in = 32'hDEADBEEF;
        tick();
        chk("rd_ack0", ack0, 1);
        chk("rd_rdata", rdata, 32'hDEADBEEF);
        chk("rd_gnt_off", gnt0, 0);
        tick();
        chk("rd_ack_off", ack0, 0);
        chk("rd_rdata_0", rdata, 32'd0);

        // Single write from requester 1
        req1 = 1'b1; addr1 = 32'h200; wdata1 = 32'h12345678; we1 = 1'b1;
        tick();
        chk("wr_gnt1", gnt1, 1);
        chk("wr_gnt0", gnt0, 0);
        chk("wr_addr", address, 32'h200);
        chk("wr_dout", data_out, 32'h12345678);
        chk("wr_we", we, 1);
        req1 = 1'b0; we1 = 1'b0;
        tick();
        chk("wr_ack1", ack1, 1);
        chk("wr_we_off", we, 0);
        chk("wr_ack0", ack0, 0);
        tick();
        chk("wr_ack_off", ack1, 0);
        chk("wr_addr_hold", address, 32'h200);
        chk("wr_dout_hold", data_out, 32'h12345678);

        // Contention: both held high for four transactions
        do_reset();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 32'h10; addr1 = 32'h20;
        for (int t = 0; t < 4; t++) begin
            int n;
            n = 0;
            do begin
                tick();
                n++;
            end while (!(gnt0 || gnt1) && n < 8);
            chk("arb_seen", {31'd0, gnt0 | gnt1}, 1);
            chk("arb_excl", {31'd0, gnt0 & gnt1}, 0);
            chk("arb_win", {31'd0, gnt1}, RR ? 32'(t % 2) : 32'd0);
            tick();
            chk("arb_ack_excl", {31'd0, ack0 & ack1}, 0);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(6);

        // MEM_LAT=3 read on the second instance
        do_reset();
        req0 = 1'b1; addr0 = 32'h300; we0 = 1'b0; data_in = 32'hCAFEF00D;
        tick();
        chk("l3_gnt0", g0_3, 1);
        chk("l3_we_c1", we_3, 0);
        req0 = 1'b0;
        tick();
        chk("l3_ack_c2", a0_3, 0);
        chk("l3_we_c2", we_3, 0);
        tick();
        chk("l3_ack_c3", a0_3, 0);
        tick();
        chk("l3_ack_c4", a0_3, 1);
        chk("l3_rdata", rd_3, 32'hCAFEF00D);
        chk("l3_we_c4", we_3, 0);
        tick();
        chk("l3_ack_c5", a0_3, 0);

        // Reset while waiting on a MEM_LAT=3 read
        do_reset();
        req0 = 1'b1; addr0 = 32'h500; data_in = 32'hFFFFFFFF;
        tick();
        chk("rw_gnt0", g0_3, 1);
        req0 = 1'b0;
        tick();
        chk("rw_wait_noack", a0_3, 0);
        #2 resetn = 1'b0;
        #1;
        chk("rw_ctl0", {27'd0, g0_3, g1_3, a0_3, a1_3, we_3}, 32'd0);
        chk("rw_rdata0", rd_3, 32'd0);
        chk("rw_addr0", ad_3, 32'd0);
        chk("rw_dout0", do_3, 32'd0);
        tick();
        chk("rw_held_ack", {30'd0, a0_3, a1_3}, 0);
        tick();
        chk("rw_held_ack2", {30'd0, a0_3, a1_3}, 0);
        resetn = 1'b1;
        req0 = 1'b1; addr0 = 32'h40;
        tick();
        chk("rw_regnt", g0_3, 1);
        chk("rw_readdr", ad_3, 32'h40);
        req0 = 1'b0;
        tick(3);
        chk("rw_reack", a0_3, 1);
        chk("rw_rerdata", rd_3, 32'hFFFFFFFF);
        tick();

        // req1 pulses only across the edge where req0 wins
        do_reset();
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'h60; addr1 = 32'h70; we0 = 1'b0; we1 = 1'b1;
        tick();
        req1 = 1'b0;
        chk("pulse_gnt0", gnt0, 1);
        chk("pulse_gnt1", gnt1, 0);
        req0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("pulse_no_aux", {30'd0, gnt1, ack1}, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1: memory read latency in cycles after the address cycle, legal range 1..4.
REQ-002 SHALL have ports clk  in  1  clock; resetn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports req0/req1  in  1  access request from requester 0 (core) / requester 1 (debug/DMA).
REQ-004 SHALL have ports addr0/addr1  in  32, wdata0/wdata1  in  32, we0/we1  in  1: per-requester address, write data and write enable.
REQ-005 SHALL have ports gnt0/gnt1  out  1: one-cycle grant pulse; the request was accepted and its inputs latched.
REQ-006 SHALL have ports ack0/ack1  out  1: one-cycle completion pulse; rdata  out  32: read data, valid only while an ack is high, 0 otherwise.
REQ-007 SHALL have memory-side ports address  out  32, data_out  out  32, we  out  1, data_in  in  32.

Function
REQ-008 SHALL implement FSM IDLE -> ACCESS -> WAIT -> IDLE, with a 3-bit latency counter.
REQ-009 In IDLE with any req high, SHALL select one winner, latch its addr/wdata/we into address/data_out/a write flag, and enter ACCESS on that edge.
REQ-010 In ACCESS, SHALL assert gnt of the winner for exactly one cycle, assert we for that cycle only if the latched write flag is 1, and enter WAIT.
REQ-011 In WAIT, SHALL assert the winner's ack when the counter reaches MEM_LAT for a read, or 1 for a write, then return to IDLE on the next edge.
REQ-012 Read latency SHALL be MEM_LAT+1 cycles from the arbitration edge to ack, with rdata = data_in in the ack cycle; write latency SHALL be 2 cycles.
REQ-013 address and data_out SHALL hold their last latched values outside ACCESS; we SHALL be 0 in every state except ACCESS.
REQ-014 SHALL keep at most one transaction outstanding, and SHALL ignore req changes after latching until IDLE.
REQ-015 A requester that drops req before being granted SHALL NOT be granted; a req still high after its ack SHALL be arbitrated as a new transaction in the next IDLE.
REQ-016 When req0 and req1 are both high in IDLE, the winner SHALL follow REQ-021/REQ-022.
REQ-017 SHALL never assert gnt0 and gnt1 together, nor ack0 and ack1 together.

Reset
REQ-018 While resetn=0, independent of clk, SHALL force state IDLE, counter 0, address 0, data_out 0, we 0, gnt0/gnt1 0, ack0/ack1 0, rdata 0, and last-grant = 1.
REQ-019 Reset mid-transaction SHALL abandon the access with no ack issued.
REQ-020 After resetn rises, arbitration SHALL be allowed from the first clk edge.

Configuration
REQ-021 With MEM_ARB_RR_EN defined, SHALL use round-robin: on contention the requester not granted last wins, and last-grant updates on every grant.
REQ-022 Without MEM_ARB_RR_EN, SHALL use fixed priority: req0 always beats req1, and the last-grant register SHALL be absent.

Structure
REQ-023 Package mem_arb_pkg SHALL hold the FSM state encoding (IDLE, ACCESS, WAIT), requester index constants REQ_CORE=0 and REQ_AUX=1, and MEM_LAT range limits.
REQ-024 Winner selection SHALL be a combinational sub-module arb_pick (inputs req0, req1, last; output winner, valid), instantiated once.

Verification
REQ-025 MEM_LAT=1, req0 read addr 0x100, data_in=0xDEADBEEF in the ack cycle -> gnt0 at cycle 1, address=0x100, we=0, ack0 at cycle 2 with rdata=0xDEADBEEF.
REQ-026 req1 write addr 0x200 data 0x12345678 -> gnt1 at cycle 1 with address=0x200, data_out=0x12345678, we=1 for that cycle only, and ack1 at cycle 2.
REQ-027 Both requesters held high for 4 transactions -> RR build grants 0,1,0,1; fixed build grants 0,0,0,0.
REQ-028 MEM_LAT=3 read -> ack at cycle 4, and we stays 0 throughout.
REQ-029 resetn pulled low in WAIT during a read -> all outputs 0 immediately, no ack; the next req0 after release is granted normally.
REQ-030 req1 raised and dropped within the cycle that req0 is arbitrated -> no gnt1 and no ack1 are issued.
